lcd_byte_writer: RTL and testbench
==================================

# lcd_byte_writer

Transfers one command or character byte to the HD44780-compatible character LCD over its 4-bit bus. It sits directly downstream of the LCD power-on `initialization` block and is enabled once that block asserts `init_done`. It serves a byte-level valid/ready producer, such as a message or cursor sequencer. For each byte it splits the value into high and low nibbles, generates the setup, enable-pulse and gap timing, and then waits out the command's execution time before accepting the next byte.

## Interface
Parameters (all counts in clocks at 50 MHz):
- `T_SETUP`, 2: RS/data setup before the E rising edge.
- `T_E_HIGH`, 12: E pulse width.
- `T_NIBBLE_GAP`, 50: E low between the two nibbles.
- `T_CMD_WAIT`, 2000: post-byte wait (40 µs).
- `T_CLEAR_WAIT`, 82000: post-byte wait for clear/home (1.64 ms).

Ports:
- `clk`, in, 1: single system clock.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `init_done`, in, 1: high when the power-on initialization is complete; level-sensitive.
- `byte_valid`, in, 1: producer has a byte.
- `byte_data`, in, 8: command or character code.
- `byte_rs`, in, 1: 0 = command, 1 = character data.
- `byte_ready`, out, 1: writer can accept a byte.
- `busy`, out, 1: a transfer or post-byte wait is in progress.
- `lcd_e`, out, 1: LCD enable.
- `lcd_rs`, out, 1: LCD register select.
- `lcd_rw`, out, 1: LCD read/write select; constant 0 (write only).
- `lcd_d`, out, 4: LCD data bus (D7..D4).

## Operation
- **Handshake**
  - `byte_ready = (state == IDLE) && init_done`.
  - A byte is accepted on a rising edge where `byte_valid && byte_ready`.
  - `byte_data` and `byte_rs` are latched on that edge. Inputs are don't-care afterwards.
- **FSM:** IDLE → HI_SETUP → HI_PULSE → GAP → LO_SETUP → LO_PULSE → WAIT → IDLE.
  - HI_SETUP (`T_SETUP` clocks): `lcd_d` = data[7:4], `lcd_rs` = latched rs, `lcd_e` = 0.
  - HI_PULSE (`T_E_HIGH` clocks): `lcd_e` = 1; `lcd_d` and `lcd_rs` unchanged.
  - GAP (`T_NIBBLE_GAP` clocks): `lcd_e` = 0; the high nibble is held on `lcd_d`, which provides the hold time.
  - LO_SETUP (`T_SETUP` clocks): `lcd_d` = data[3:0], `lcd_e` = 0.
  - LO_PULSE (`T_E_HIGH` clocks): `lcd_e` = 1.
  - WAIT (`T_CMD_WAIT` clocks, or `T_CLEAR_WAIT` where Configuration applies): `lcd_e` = 0; the low nibble and rs are held.
- **Delay counter:** a single down-counter, 17 bits, sized to the largest parameter.
  - It is loaded with (duration − 1) on each state entry.
  - The state advances when the counter reaches 0.
  - The counter saturates at 0 and never wraps.
- **IDLE:** `lcd_e` = 0; `lcd_d` and `lcd_rs` hold their last driven values.
- **busy:** `busy = (state != IDLE)`.
- **init_done** is sampled only in IDLE.
  - If it drops mid-transfer, the current byte completes.
  - No new byte is accepted while it is low.
- **Pin ownership:** the top level muxes the LCD pins between `initialization` and this block, selected by `init_done`.
- **Outputs:** all outputs are registered. `lcd_rw` is tied to 0.

## Timing
- Reset values: state = IDLE, `lcd_e` = 0, `lcd_rs` = 0, `lcd_d` = 4'h0, `byte_ready` = 0, `busy` = 0, counter = 0.
- Cycle 0 is the accepting edge. With defaults:
  - Outputs change on cycle 1.
  - `lcd_e` is high on cycles 3–14 and 67–78, 12 clocks each.
  - `byte_ready` returns high after 2078 clocks: 2·`T_SETUP` + 2·`T_E_HIGH` + `T_NIBBLE_GAP` + `T_CMD_WAIT`.
- There is no back-to-back acceptance: at most one byte per full sequence.
- `byte_valid` held high while `byte_ready` = 0 has no effect.
- `rst_n` asserted mid-transfer forces reset values immediately, including `lcd_e` = 0. The partially written byte is lost, and the upstream block must re-run initialization.

## Configuration
- Macro: `LCD_WRITER_CLEAR_DETECT_EN`.
- **Defined:** a command byte (`byte_rs` = 0) of 8'h01 (clear) or 8'h02/8'h03 (home) uses `T_CLEAR_WAIT` in WAIT. All other bytes use `T_CMD_WAIT`.
- **Undefined:** every byte uses `T_CMD_WAIT`. The producer is then responsible for spacing clear/home commands itself.

## Structure
- Package `lcd_pkg`:
  - FSM state encoding.
  - Default timing constants, shared with `initialization`.
  - Command codes `LCD_CMD_CLEAR` = 8'h01 and `LCD_CMD_HOME` = 8'h02.
  - Counter width constant `LCD_DLY_W` = 17.
- Sub-module `lcd_delay_counter`: loadable saturating down-counter with a `done` flag. It is reused by `initialization`.

## Test plan
- Reset with `init_done` = 0 and `byte_valid` = 1 → `byte_ready` = 0, `lcd_e` never toggles.
- `init_done` = 1, send 8'h48 with rs = 1 →
  - `lcd_rs` = 1.
  - `lcd_d` = 4'h4 during the first E pulse and 4'h8 during the second.
  - E pulses are 12 clocks wide with a 50-clock gap.
  - `byte_ready` is high again at clock 2078.
- With the macro defined, send 8'h01 with rs = 0 → `byte_ready` returns at clock 82078. With the macro undefined → clock 2078.
- Send 8'h01 with rs = 1 (macro defined) → 2078-clock wait, since clear detection applies to commands only.
- Drop `init_done` during GAP → the byte completes normally and `byte_ready` stays 0 afterwards.
- Assert `rst_n` = 0 during HI_PULSE → `lcd_e` = 0 asynchronously, outputs return to reset values, FSM returns to IDLE.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 4-bit LCD path: state encoding, default
// timing (clocks at 50 MHz), command codes and delay-counter width.
`default_nettype none

package lcd_pkg;

   localparam int unsigned LCD_DLY_W = 17;

   localparam int unsigned LCD_T_SETUP       = 2;
   localparam int unsigned LCD_T_E_HIGH      = 12;
   localparam int unsigned LCD_T_NIBBLE_GAP  = 50;
   localparam int unsigned LCD_T_CMD_WAIT    = 2000;
   localparam int unsigned LCD_T_CLEAR_WAIT  = 82000;

   localparam logic [7:0] LCD_CMD_CLEAR = 8'h01;
   localparam logic [7:0] LCD_CMD_HOME  = 8'h02;

   localparam logic [2:0] WR_IDLE     = 3'd0;
   localparam logic [2:0] WR_HI_SETUP = 3'd1;
   localparam logic [2:0] WR_HI_PULSE = 3'd2;
   localparam logic [2:0] WR_GAP      = 3'd3;
   localparam logic [2:0] WR_LO_SETUP = 3'd4;
   localparam logic [2:0] WR_LO_PULSE = 3'd5;
   localparam logic [2:0] WR_WAIT     = 3'd6;

   // Home ignores bit 0, so 8'h03 is a home command as well.
   function automatic logic is_clear_home(input logic [7:0] data, input logic rs);
      return !rs && ((data == LCD_CMD_CLEAR) || ({data[7:1], 1'b0} == LCD_CMD_HOME));
   endfunction

endpackage

`default_nettype wire

// File: rtl/lcd_byte_writer_if.sv
// Byte-level valid/ready channel between a producer and lcd_byte_writer.
`default_nettype none

interface lcd_byte_writer_if;
   logic       byte_valid;
   logic [7:0] byte_data;
   logic       byte_rs;
   logic       byte_ready;

   modport master (output byte_valid, output byte_data, output byte_rs, input byte_ready);
   modport slave  (input byte_valid, input byte_data, input byte_rs, output byte_ready);
endinterface

`default_nettype wire

// File: rtl/lcd_delay_counter.sv
// Loadable down-counter that saturates at zero; done is high while at zero.
`default_nettype none

module lcd_delay_counter
   import lcd_pkg::*;
#(
   parameter int unsigned W = LCD_DLY_W
) (
   input  wire logic         clk,
   input  wire logic         rst_n,
   input  wire logic         load,
   input  wire logic [W-1:0] load_val,
   output logic              done
);

   logic [W-1:0] count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (count != '0) begin
         count <= count - 1'b1;
      end
   end

   assign done = (count == '0);

endmodule

`default_nettype wire

// File: rtl/lcd_byte_writer.sv
// Writes one command/character byte to an HD44780 LCD as two 4-bit nibbles.
// Optional macro LCD_WRITER_CLEAR_DETECT_EN: long post-byte wait for clear/home.
`default_nettype none

module lcd_byte_writer
   import lcd_pkg::*;
#(
   parameter int unsigned T_SETUP      = LCD_T_SETUP,
   parameter int unsigned T_E_HIGH     = LCD_T_E_HIGH,
   parameter int unsigned T_NIBBLE_GAP = LCD_T_NIBBLE_GAP,
   parameter int unsigned T_CMD_WAIT   = LCD_T_CMD_WAIT,
   parameter int unsigned T_CLEAR_WAIT = LCD_T_CLEAR_WAIT
) (
   input  wire logic         clk,
   input  wire logic         rst_n,
   input  wire logic         init_done,
   lcd_byte_writer_if.slave  byte_if,
   output logic              busy,
   output logic              lcd_e,
   output logic              lcd_rs,
   output logic              lcd_rw,
   output logic [3:0]        lcd_d
);

   localparam logic [LCD_DLY_W-1:0] SETUP_LD = LCD_DLY_W'(T_SETUP - 1);
   localparam logic [LCD_DLY_W-1:0] E_LD     = LCD_DLY_W'(T_E_HIGH - 1);
   localparam logic [LCD_DLY_W-1:0] GAP_LD   = LCD_DLY_W'(T_NIBBLE_GAP - 1);
   localparam logic [LCD_DLY_W-1:0] CMD_LD   = LCD_DLY_W'(T_CMD_WAIT - 1);
`ifdef LCD_WRITER_CLEAR_DETECT_EN
   localparam logic [LCD_DLY_W-1:0] CLEAR_LD = LCD_DLY_W'(T_CLEAR_WAIT - 1);
`endif

   logic [2:0]           state;
   logic [2:0]           next_state;
   logic                 cnt_load;
   logic [LCD_DLY_W-1:0] cnt_val;
   logic                 cnt_done;
   logic [LCD_DLY_W-1:0] wait_ld;
   logic                 accept;
   logic                 ready_q;
   logic [7:0]           data_q;
   logic                 rs_q;
   logic                 e_nxt;
   logic                 rs_nxt;
   logic [3:0]           d_nxt;

   assign accept = byte_if.byte_valid && ready_q;

`ifdef LCD_WRITER_CLEAR_DETECT_EN
   assign wait_ld = is_clear_home(data_q, rs_q) ? CLEAR_LD : CMD_LD;
`else
   assign wait_ld = CMD_LD;
`endif

   lcd_delay_counter #(.W(LCD_DLY_W)) u_dly (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (cnt_load),
      .load_val (cnt_val),
      .done     (cnt_done)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= WR_IDLE;
         data_q <= 8'h00;
         rs_q   <= 1'b0;
      end else begin
         state <= next_state;
         if (accept) begin
            data_q <= byte_if.byte_data;
            rs_q   <= byte_if.byte_rs;
         end
      end
   end

   always_comb begin
      next_state = state;
      cnt_load   = 1'b0;
      cnt_val    = '0;
      case (state)
         WR_IDLE: if (accept) begin
            next_state = WR_HI_SETUP; cnt_load = 1'b1; cnt_val = SETUP_LD;
         end
         WR_HI_SETUP: if (cnt_done) begin
            next_state = WR_HI_PULSE; cnt_load = 1'b1; cnt_val = E_LD;
         end
         WR_HI_PULSE: if (cnt_done) begin
            next_state = WR_GAP; cnt_load = 1'b1; cnt_val = GAP_LD;
         end
         WR_GAP: if (cnt_done) begin
            next_state = WR_LO_SETUP; cnt_load = 1'b1; cnt_val = SETUP_LD;
         end
         WR_LO_SETUP: if (cnt_done) begin
            next_state = WR_LO_PULSE; cnt_load = 1'b1; cnt_val = E_LD;
         end
         WR_LO_PULSE: if (cnt_done) begin
            next_state = WR_WAIT; cnt_load = 1'b1; cnt_val = wait_ld;
         end
         WR_WAIT: if (cnt_done) begin
            next_state = WR_IDLE;
         end
         default: next_state = WR_IDLE;
      endcase
   end

   // Pin values follow the current state, so pins lag state entry by one clock.
   always_comb begin
      e_nxt  = (state == WR_HI_PULSE) || (state == WR_LO_PULSE);
      rs_nxt = lcd_rs;
      d_nxt  = lcd_d;
      case (state)
         WR_HI_SETUP: begin
            rs_nxt = rs_q;
            d_nxt  = data_q[7:4];
         end
         WR_LO_SETUP: d_nxt = data_q[3:0];
         default: ;
      endcase
   end

   // Handshake flags look ahead at next_state so ready returns on the IDLE entry edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lcd_e   <= 1'b0;
         lcd_rs  <= 1'b0;
         lcd_d   <= 4'h0;
         ready_q <= 1'b0;
         busy    <= 1'b0;
      end else begin
         lcd_e   <= e_nxt;
         lcd_rs  <= rs_nxt;
         lcd_d   <= d_nxt;
         ready_q <= (next_state == WR_IDLE) && init_done;
         busy    <= (next_state != WR_IDLE);
      end
   end

   assign byte_if.byte_ready = ready_q;
   assign lcd_rw             = 1'b0;

endmodule

`default_nettype wire

// File: tb/tb_lcd_byte_writer.sv
// Directed self-checking bench for lcd_byte_writer.
`default_nettype none

module tb_lcd_byte_writer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       init_done = 1'b0;
   logic       busy, lcd_e, lcd_rs, lcd_rw;
   logic [3:0] lcd_d;

   int n_cmp = 0;
   int n_err = 0;

   int rise1, fall1, rise2, fall2, e_cnt, rdy_cyc, busy_fall;
   logic [3:0] d1, d2, d1_end;
   logic       rs_s;

   lcd_byte_writer_if bus ();

   lcd_byte_writer dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .init_done (init_done),
      .byte_if   (bus),
      .busy      (busy),
      .lcd_e     (lcd_e),
      .lcd_rs    (lcd_rs),
      .lcd_rw    (lcd_rw),
      .lcd_d     (lcd_d)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
      end
   endtask

   // Sends one byte; cycle k counts edges after the accepting edge (k=0).
   task automatic xfer(input logic [7:0] data, input logic rs, input int drop_at, input int limit);
      int   n = 0;
      logic e_prev = 1'b0;
      rise1 = 0; fall1 = 0; rise2 = 0; fall2 = 0; e_cnt = 0; rdy_cyc = 0; busy_fall = 0;
      d1 = 4'h0; d2 = 4'h0; d1_end = 4'h0; rs_s = 1'b0;
      while (!bus.byte_ready && n < 100) begin
         @(posedge clk); #1; n++;
      end
      check("ready_before_send", bus.byte_ready, 1);
      bus.byte_valid = 1'b1;
      bus.byte_data  = data;
      bus.byte_rs    = rs;
      @(posedge clk); #1;
      for (int k = 1; k <= limit; k++) begin
         @(posedge clk); #1;
         if (k == drop_at) init_done = 1'b0;
         if (lcd_e && !e_prev) begin
            if (rise1 == 0) begin rise1 = k; d1 = lcd_d; rs_s = lcd_rs; end
            else begin rise2 = k; d2 = lcd_d; end
         end
         if (!lcd_e && e_prev) begin
            if (fall1 == 0) begin fall1 = k - 1; d1_end = lcd_d; end
            else fall2 = k - 1;
         end
         if (lcd_e) e_cnt++;
         if (!busy && busy_fall == 0) busy_fall = k;
         if (bus.byte_ready && rdy_cyc == 0) begin
            rdy_cyc = k;
            break;
         end
         e_prev = lcd_e;
      end
      bus.byte_valid = 1'b0;
   endtask

   task automatic check_pulses(input string tag, input logic [3:0] hi, input logic [3:0] lo, input logic rs);
      check({tag, "_rise1"}, rise1, 3);
      check({tag, "_fall1"}, fall1, 14);
      check({tag, "_rise2"}, rise2, 67);
      check({tag, "_fall2"}, fall2, 78);
      check({tag, "_e_cnt"}, e_cnt, 24);
      check({tag, "_d_hi"}, d1, hi);
      check({tag, "_d_hi_hold"}, d1_end, hi);
      check({tag, "_d_lo"}, d2, lo);
      check({tag, "_rs"}, rs_s, rs);
   endtask

   initial begin
      int e_seen;
      int r_seen;
      bus.byte_valid = 1'b1;
      bus.byte_data  = 8'h00;
      bus.byte_rs    = 1'b0;

      // Reset state, with init_done low and a pending byte.
      #12;
      check("rst_ready", bus.byte_ready, 0);
      check("rst_busy", busy, 0);
      check("rst_e", lcd_e, 0);
      check("rst_rs", lcd_rs, 0);
      check("rst_d", lcd_d, 0);
      check("rst_rw", lcd_rw, 0);
      @(negedge clk); rst_n = 1'b1;

      e_seen = 0; r_seen = 0;
      for (int k = 0; k < 20; k++) begin
         @(posedge clk); #1;
         if (lcd_e) e_seen++;
         if (bus.byte_ready) r_seen++;
      end
      check("noinit_e_seen", e_seen, 0);
      check("noinit_ready_seen", r_seen, 0);
      check("noinit_busy", busy, 0);
      bus.byte_valid = 1'b0;

      init_done = 1'b1;
      xfer(8'h48, 1'b1, 0, 2200);
      check_pulses("h48", 4'h4, 4'h8, 1'b1);
      check("h48_ready_cyc", rdy_cyc, 2078);
      check("h48_busy_fall", busy_fall, 2078);
      check("h48_rw", lcd_rw, 0);

`ifdef LCD_WRITER_CLEAR_DETECT_EN
      xfer(8'h01, 1'b0, 0, 82200);
      check("clr_cmd_ready_cyc", rdy_cyc, 82078);
`else
      xfer(8'h01, 1'b0, 0, 2200);
      check("clr_cmd_ready_cyc", rdy_cyc, 2078);
`endif
      check_pulses("clr_cmd", 4'h0, 4'h1, 1'b0);

      xfer(8'h01, 1'b1, 0, 2200);
      check("clr_data_ready_cyc", rdy_cyc, 2078);
      check("clr_data_rs", rs_s, 1);

      // init_done drops during the nibble gap.
      xfer(8'hA5, 1'b0, 30, 2200);
      check_pulses("drop", 4'hA, 4'h5, 1'b0);
      check("drop_busy_fall", busy_fall, 2078);
      check("drop_ready_cyc", rdy_cyc, 0);
      check("drop_ready_now", bus.byte_ready, 0);

      // Asynchronous reset in the middle of the high-nibble pulse.
      init_done = 1'b1;
      xfer(8'h3C, 1'b1, 0, 5);
      check("arst_pre_e", lcd_e, 1);
      check("arst_pre_d", lcd_d, 4'h3);
      check("arst_pre_rs", lcd_rs, 1);
      #2 rst_n = 1'b0;
      #1;
      check("arst_e", lcd_e, 0);
      check("arst_d", lcd_d, 0);
      check("arst_rs", lcd_rs, 0);
      check("arst_busy", busy, 0);
      check("arst_ready", bus.byte_ready, 0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      check("arst_idle_ready", bus.byte_ready, 1);
      check("arst_idle_busy", busy, 0);
      check("arst_idle_e", lcd_e, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
